sphere_phys_n: RTL and testbench
================================

SPHERE_PHYS_N -- requirements
Module: sphere_phys_n

Interface
REQ-001 Parameter NUM_SPHERES, default 4, number of spheres (2..16); IDXW = $clog2(NUM_SPHERES).
REQ-002 Parameter GRAVITY, default 64'hFFFFFFFE00000000, signed 32.32 vertical acceleration per frame (-2.0).
REQ-003 Parameter FLOOR_Y, default 1440, integer; floor plane at y = -FLOOR_Y.
REQ-004 Parameter SPAWN_Y, default 304, integer respawn height.
REQ-005 Parameter LFSR_SEED, default 32'hACE12468, nonzero reset value of the internal 32-bit LFSR.
REQ-006 Clk  input  1  sole clock; all state on posedge Clk.
REQ-007 Reset  input  1  synchronous, active-high reset.
REQ-008 frame_tick  input  1  one-cycle strobe requesting one physics frame.
REQ-009 Hit  input  1  strobe marking sphere Hit_index for respawn.
REQ-010 Hit_index  input  IDXW  sphere targeted by Hit.
REQ-011 Read_index  input  IDXW  sphere selected for readout.
REQ-012 Sphere_pos  output  192  vector {x,y,z} of Read_index sphere, [2]=x, [1]=y, [0]=z, each signed 32.32.
REQ-013 Sphere_col  output  24  RGB of Read_index sphere.
REQ-014 Busy  output  1  high while a frame update is in progress.
REQ-015 Frame_done  output  1  one-cycle pulse when a frame completes.
REQ-016 Overrun  output  1  sticky; set when a frame_tick is dropped.

Function
REQ-017 FSM states IDLE, UPDATE, DONE; IDLE->UPDATE on frame_tick; UPDATE holds for exactly NUM_SPHERES cycles, sphere index counter 0..NUM_SPHERES-1, one sphere per cycle; UPDATE->DONE after last index; DONE->UPDATE if pending flag set (clearing it), else DONE->IDLE.
REQ-018 Busy is high in UPDATE and DONE; Frame_done is high only in DONE; frame latency = NUM_SPHERES+1 cycles from tick to Frame_done.
REQ-019 frame_tick while Busy with pending clear sets pending; frame_tick while pending already set is dropped and sets Overrun.
REQ-020 Normal update of sphere i: v' = v + {0, GRAVITY, 0}; p' = p + v'; all adds 64-bit two's-complement, wrap on overflow.
REQ-021 Respawn condition evaluated on pre-update state: p.y < -(FLOOR_Y<<32) (strict) OR hit bit i set.
REQ-022 Respawn: p' = {0, SPAWN_Y<<32, 0}; v.x' = sign-extended r[7:0] * 2^-4; v.y' = unsigned r[15:8] * 2^-4; v.z' = 0; col' = r[23:0]; r = current LFSR value.
REQ-023 LFSR: 32-bit Galois, taps 32,22,2,1, advances every Clk cycle when not in reset.
REQ-024 Hit sets hit bit Hit_index; updating sphere i clears bit i, except a Hit to i in the same cycle leaves it set (applies next frame).
REQ-025 Readout registered: Sphere_pos/Sphere_col reflect state of Read_index one cycle after sampling; a read coinciding with that sphere's update returns pre-update value.

Reset
REQ-026 Reset forces state IDLE, index 0, pending 0, Overrun 0, all hit bits 0, LFSR = LFSR_SEED.
REQ-027 Reset sets sphere i to p = {0, SPAWN_Y<<32, 0}, v = 0, col = 24'hFFFFFF; Sphere_pos/Sphere_col reset to sphere 0 values; Busy, Frame_done 0.
REQ-028 Reset mid-frame abandons the frame; no Frame_done is emitted.

Configuration
REQ-029 Macro SPHERE_BOUNCE_EN: when defined, floor condition (REQ-021, non-hit) bounces instead of respawning: p.y' = -(FLOOR_Y<<32), v.y' = -(v.y - (v.y>>>2)), x/z updated normally; hit still respawns.
REQ-030 Without SPHERE_BOUNCE_EN, floor condition respawns per REQ-022.

Verification
REQ-031 Reset, one frame_tick, read sphere 0 -> Busy 5 cycles (N=4), Frame_done at tick+5, pos.y = 302.0, vel.y = -2.0.
REQ-032 Three frames, no hits -> sphere 2 pos.y = 304-2-4-6 = 292.0.
REQ-033 Hit index 1 then frame -> sphere 1 pos = {0,304.0,0}, col = LFSR[23:0] at its update cycle, others fall normally.
REQ-034 tick, tick during UPDATE, third tick during UPDATE -> two frames run back-to-back, Overrun = 1, exactly 2 Frame_done pulses.
REQ-035 Drive sphere 0 below y=-1440 over frames -> next frame respawns at 304.0 (macro off) or clamps to -1440.0 with v.y negated and damped by 1/4 (macro on).
REQ-036 Hit to sphere k in its update cycle -> hit bit remains, respawn on following frame; Reset mid-UPDATE -> no Frame_done, all spheres at reset values.

Source files
------------

// File: rtl/sphere_phys_n.sv
// Gravity/respawn physics for NUM_SPHERES spheres, one sphere per cycle; a frame takes NUM_SPHERES+1 cycles to Frame_done.
// No backpressure: one tick queues behind a running frame, further ticks are dropped and latch Overrun. Option: SPHERE_BOUNCE_EN.
module sphere_phys_n #(
   parameter int          NUM_SPHERES = 4,
   parameter logic [63:0] GRAVITY     = 64'hFFFFFFFE00000000,
   parameter int          FLOOR_Y     = 1440,
   parameter int          SPAWN_Y     = 304,
   parameter logic [31:0] LFSR_SEED   = 32'hACE12468,
   localparam int         IDXW        = $clog2(NUM_SPHERES)
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            frame_tick,
   input  logic            Hit,
   input  logic [IDXW-1:0] Hit_index,
   input  logic [IDXW-1:0] Read_index,
   output logic [191:0]    Sphere_pos,
   output logic [23:0]     Sphere_col,
   output logic            Busy,
   output logic            Frame_done,
   output logic            Overrun
);

   typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

   localparam logic [IDXW-1:0]    LAST_IDX  = IDXW'(NUM_SPHERES - 1);
   localparam logic signed [63:0] FLOOR_NEG = -(64'(FLOOR_Y) << 32);
   localparam logic [63:0]        SPAWN_P   = 64'(SPAWN_Y) << 32;
   localparam logic [31:0]        LFSR_MASK = 32'h80200003;

   state_t                  state, state_nxt;
   logic [IDXW-1:0]         idx, idx_nxt;
   logic                    pending, pending_nxt, overrun_nxt;
   logic [31:0]             lfsr;
   logic [NUM_SPHERES-1:0]  hit, hit_nxt;

   logic [NUM_SPHERES-1:0][63:0] px, py, pz, vx, vy, vz;
   logic [NUM_SPHERES-1:0][23:0] col;

   logic [63:0] npx, npy, npz, nvx, nvy, nvz;
   logic [23:0] ncol;
   logic        upd_en, floor_cond, respawn;

   assign Busy       = (state != IDLE);
   assign Frame_done = (state == DONE);

   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      pending_nxt = pending;
      overrun_nxt = Overrun;
      case (state)
         IDLE: begin
            if (frame_tick) begin
               state_nxt = UPDATE;
               idx_nxt   = '0;
            end
         end
         UPDATE: begin
            if (frame_tick) begin
               if (pending) overrun_nxt = 1'b1;
               else         pending_nxt = 1'b1;
            end
            if (idx == LAST_IDX) begin
               state_nxt = DONE;
               idx_nxt   = '0;
            end else begin
               idx_nxt = idx + IDXW'(1);
            end
         end
         DONE: begin
            // A tick landing in DONE with nothing queued is consumed immediately.
            if (pending) begin
               state_nxt   = UPDATE;
               pending_nxt = 1'b0;
               if (frame_tick) overrun_nxt = 1'b1;
            end else if (frame_tick) begin
               state_nxt = UPDATE;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      upd_en     = (state == UPDATE);
      floor_cond = $signed(py[idx]) < FLOOR_NEG;
      nvx        = vx[idx];
      nvy        = vy[idx] + GRAVITY;
      nvz        = vz[idx];
      ncol       = col[idx];
      npx        = px[idx] + nvx;
      npy        = py[idx] + nvy;
      npz        = pz[idx] + nvz;
`ifdef SPHERE_BOUNCE_EN
      respawn = hit[idx];
      if (floor_cond) begin
         nvy = -(vy[idx] - 64'($signed(vy[idx]) >>> 2));
         npy = FLOOR_NEG;
      end
`else
      respawn = hit[idx] | floor_cond;
`endif
      // Respawn velocity is the random byte scaled by 1/16 in 32.32.
      if (respawn) begin
         npx  = '0;
         npy  = SPAWN_P;
         npz  = '0;
         nvx  = {{28{lfsr[7]}}, lfsr[7:0], 28'd0};
         nvy  = {28'd0, lfsr[15:8], 28'd0};
         nvz  = '0;
         ncol = lfsr[23:0];
      end
   end

   always_comb begin
      hit_nxt = hit;
      if (upd_en) hit_nxt[idx] = 1'b0;
      if (Hit)    hit_nxt[Hit_index] = 1'b1;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= IDLE;
         idx        <= '0;
         pending    <= 1'b0;
         Overrun    <= 1'b0;
         hit        <= '0;
         lfsr       <= LFSR_SEED;
         px         <= '0;
         py         <= {NUM_SPHERES{SPAWN_P}};
         pz         <= '0;
         vx         <= '0;
         vy         <= '0;
         vz         <= '0;
         col        <= {NUM_SPHERES{24'hFFFFFF}};
         Sphere_pos <= {64'd0, SPAWN_P, 64'd0};
         Sphere_col <= 24'hFFFFFF;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         pending    <= pending_nxt;
         Overrun    <= overrun_nxt;
         hit        <= hit_nxt;
         lfsr       <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'd0);
         Sphere_pos <= {px[Read_index], py[Read_index], pz[Read_index]};
         Sphere_col <= col[Read_index];
         if (upd_en) begin
            px[idx]  <= npx;
            py[idx]  <= npy;
            pz[idx]  <= npz;
            vx[idx]  <= nvx;
            vy[idx]  <= nvy;
            vz[idx]  <= nvz;
            col[idx] <= ncol;
         end
      end
   end

endmodule

// File: tb/tb_sphere_phys_n.sv
// Bench for sphere_phys_n: directed vector table, corner sequences, then random traffic against a frame-level model.
module tb_sphere_phys_n;
   localparam int          N         = 4;
   localparam int          IDXW      = 2;
   localparam longint      ONE       = 64'sh1_0000_0000;
   localparam longint      GRAV      = -2 * ONE;
   localparam longint      FLOOR_NEG = -1440 * ONE;
   localparam longint      SPAWN     = 304 * ONE;
   localparam logic [31:0] SEED      = 32'hACE12468;

   logic            Clk = 1'b0;
   logic            Reset = 1'b1;
   logic            frame_tick = 1'b0;
   logic            Hit = 1'b0;
   logic [IDXW-1:0] Hit_index = '0;
   logic [IDXW-1:0] Read_index = '0;
   logic [191:0]    Sphere_pos;
   logic [23:0]     Sphere_col;
   logic            Busy, Frame_done, Overrun;

   always #5 Clk = ~Clk;

   sphere_phys_n dut (
      .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .Hit(Hit),
      .Hit_index(Hit_index), .Read_index(Read_index), .Sphere_pos(Sphere_pos),
      .Sphere_col(Sphere_col), .Busy(Busy), .Frame_done(Frame_done), .Overrun(Overrun)
   );

   // Reference model: sphere state, hit flags, and the start cycle of every accepted frame.
   longint      mpx[N], mpy[N], mpz[N], mvx[N], mvy[N], mvz[N];
   logic [23:0] mcol[N];
   bit          mhit[N];
   logic [31:0] m_lfsr;
   bit          m_ovr;
   logic [191:0] m_rd_pos;
   logic [23:0] m_rd_col;
   int          fr_start[$];
   int          last_start;
   int          cyc = 0;
   bit          chk_en = 0;
   int          n_cmp = 0, n_bad = 0;

   task automatic chk(string nm, logic [191:0] act, logic [191:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] lfsr_next(logic [31:0] v);
      return v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
   endfunction

   function automatic bit busy_at(int c);
      foreach (fr_start[j]) if (c >= fr_start[j] && c <= fr_start[j] + N) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit done_at(int c);
      foreach (fr_start[j]) if (c == fr_start[j] + N) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mpx[i] = 0; mpy[i] = SPAWN; mpz[i] = 0;
         mvx[i] = 0; mvy[i] = 0; mvz[i] = 0;
         mcol[i] = 24'hFFFFFF; mhit[i] = 1'b0;
      end
      m_lfsr = SEED;
      m_ovr = 1'b0;
      fr_start.delete();
      last_start = -1000;
      m_rd_pos = {64'd0, SPAWN, 64'd0};
      m_rd_col = 24'hFFFFFF;
      chk_en = 1'b1;
   endtask

   task automatic sphere_update(int i);
      bit fl, bounce;
      fl = mpy[i] < FLOOR_NEG;
      bounce = 1'b0;
`ifdef SPHERE_BOUNCE_EN
      bounce = 1'b1;
`endif
      if (mhit[i] || (fl && !bounce)) begin
         mpx[i] = 0; mpy[i] = SPAWN; mpz[i] = 0;
         mvx[i] = longint'($signed(m_lfsr[7:0])) * (ONE / 16);
         mvy[i] = longint'(m_lfsr[15:8]) * (ONE / 16);
         mvz[i] = 0;
         mcol[i] = m_lfsr[23:0];
      end else if (fl) begin
         mvy[i] = -(mvy[i] - (mvy[i] >>> 2));
         mpx[i] += mvx[i];
         mpz[i] += mvz[i];
         mpy[i] = FLOOR_NEG;
      end else begin
         mvy[i] += GRAV;
         mpx[i] += mvx[i];
         mpy[i] += mvy[i];
         mpz[i] += mvz[i];
      end
   endtask

   task automatic model_edge();
      int upd, ns;
      if (Reset) begin
         model_reset();
         return;
      end
      m_rd_pos = {mpx[Read_index], mpy[Read_index], mpz[Read_index]};
      m_rd_col = mcol[Read_index];
      upd = -1;
      foreach (fr_start[j]) if (cyc >= fr_start[j] && cyc < fr_start[j] + N) upd = cyc - fr_start[j];
      if (upd >= 0) begin
         sphere_update(upd);
         mhit[upd] = 1'b0;
      end
      if (Hit) mhit[Hit_index] = 1'b1;
      if (frame_tick) begin
         if (cyc >= last_start) begin
            ns = (cyc + 1 > last_start + N + 1) ? cyc + 1 : last_start + N + 1;
            fr_start.push_back(ns);
            last_start = ns;
         end else begin
            m_ovr = 1'b1;
         end
      end
      m_lfsr = lfsr_next(m_lfsr);
   endtask

   // Check this cycle's outputs, advance the model through the coming edge, then step the clock.
   task automatic cycle();
      if (chk_en) begin
         chk("busy", Busy, busy_at(cyc));
         chk("frame_done", Frame_done, done_at(cyc));
         chk("overrun", Overrun, m_ovr);
         chk("pos", Sphere_pos, m_rd_pos);
         chk("col", Sphere_col, m_rd_col);
      end
      model_edge();
      @(posedge Clk);
      @(negedge Clk);
      cyc++;
   endtask

   task automatic do_reset();
      Reset = 1'b1; frame_tick = 1'b0; Hit = 1'b0;
      cycle();
      Reset = 1'b0;
   endtask

   task automatic frame();
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
      repeat (N + 2) cycle();
   endtask

   task automatic read_pos(int r, string nm, longint ex, longint ey, longint ez);
      Read_index = IDXW'(r);
      cycle();
      chk(nm, Sphere_pos, {ex, ey, ez});
   endtask

   typedef struct {
      int     frames;
      bit     do_hit;
      int     hidx;
      int     rd;
      longint ey;
      bit     white;
   } vec_t;

   vec_t vt[7];

   initial begin
      int nd;
      bit bs;
      vt[0] = '{1, 1'b0, 0, 0, 302 * ONE, 1'b1};
      vt[1] = '{3, 1'b0, 0, 2, 292 * ONE, 1'b1};
      vt[2] = '{2, 1'b0, 0, 3, 298 * ONE, 1'b1};
      vt[3] = '{1, 1'b1, 1, 1, 304 * ONE, 1'b0};
      vt[4] = '{1, 1'b1, 1, 0, 302 * ONE, 1'b1};
      vt[5] = '{5, 1'b0, 0, 1, 274 * ONE, 1'b1};
      vt[6] = '{0, 1'b0, 0, 2, 304 * ONE, 1'b1};

      @(negedge Clk);
      do_reset();
      chk("rst_busy", Busy, 1'b0);
      chk("rst_done", Frame_done, 1'b0);
      chk("rst_ovr", Overrun, 1'b0);
      chk("rst_pos", Sphere_pos, {64'd0, SPAWN, 64'd0});
      chk("rst_col", Sphere_col, 24'hFFFFFF);

      for (int k = 0; k < 7; k++) begin
         do_reset();
         if (vt[k].do_hit) begin
            Hit = 1'b1; Hit_index = IDXW'(vt[k].hidx);
            cycle();
            Hit = 1'b0;
         end
         repeat (vt[k].frames) frame();
         Read_index = IDXW'(vt[k].rd);
         cycle();
         chk("vec_pos", Sphere_pos, {64'd0, vt[k].ey, 64'd0});
         if (vt[k].white) chk("vec_col", Sphere_col, 24'hFFFFFF);
      end

      // Frame latency: Busy for N+1 cycles, Frame_done in the last of them.
      do_reset();
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         chk("lat_busy", Busy, k <= 5);
         chk("lat_done", Frame_done, k == 5);
         cycle();
      end
      read_pos(0, "lat_pos", 0, 302 * ONE, 0);
      frame();
      read_pos(0, "lat_vel", 0, 298 * ONE, 0);

      // Queued tick plus a dropped one.
      do_reset();
      frame_tick = 1'b1; cycle();
      frame_tick = 1'b0; cycle();
      frame_tick = 1'b1; cycle();
      frame_tick = 1'b0; cycle();
      frame_tick = 1'b1; cycle();
      frame_tick = 1'b0;
      nd = 0;
      repeat (16) begin
         nd += int'(Frame_done);
         cycle();
      end
      chk("ovr_pulses", 192'(nd), 192'd2);
      chk("ovr_flag", Overrun, 1'b1);

      // Hit landing in sphere 2's own update cycle takes effect next frame.
      do_reset();
      frame_tick = 1'b1; cycle();
      frame_tick = 1'b0; cycle(); cycle();
      Hit = 1'b1; Hit_index = 2'd2; cycle();
      Hit = 1'b0;
      repeat (N) cycle();
      read_pos(2, "hitupd_f1", 0, 302 * ONE, 0);
      frame();
      read_pos(2, "hitupd_f2", 0, SPAWN, 0);

      // Reset in the middle of UPDATE.
      do_reset();
      frame_tick = 1'b1; cycle();
      frame_tick = 1'b0; cycle(); cycle();
      Reset = 1'b1; cycle();
      Reset = 1'b0;
      nd = 0; bs = 1'b0;
      repeat (8) begin
         nd += int'(Frame_done);
         bs |= Busy;
         cycle();
      end
      chk("midrst_done", 192'(nd), 192'd0);
      chk("midrst_busy", bs, 1'b0);
      for (int i = 0; i < N; i++) begin
         read_pos(i, "midrst_pos", 0, SPAWN, 0);
         chk("midrst_col", Sphere_col, 24'hFFFFFF);
      end

      // Fall through the floor.
      do_reset();
      repeat (42) frame();
      read_pos(0, "floor_below", 0, -1502 * ONE, 0);
      frame();
`ifdef SPHERE_BOUNCE_EN
      read_pos(0, "floor_clamp", 0, FLOOR_NEG, 0);
      frame();
      read_pos(0, "floor_bounce", 0, -1379 * ONE, 0);
`else
      read_pos(0, "floor_respawn", 0, SPAWN, 0);
`endif

      // Random traffic against the model.
      do_reset();
      repeat (3000) begin
         frame_tick = ($urandom_range(3) == 0);
         Hit        = ($urandom_range(7) == 0);
         Hit_index  = IDXW'($urandom_range(N - 1));
         Read_index = IDXW'($urandom_range(N - 1));
         Reset      = ($urandom_range(499) == 0);
         cycle();
      end
      Reset = 1'b0; frame_tick = 1'b0; Hit = 1'b0;
      repeat (12) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
